// File: rtl/syx_dump_tx.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : syx_dump_tx                                                   |
// | Purpose  : Serialises a patch-memory region as one SysEx frame           |
// |            F0, ID, channel, length, data..., [checksum], F7 on a         |
// |            valid/ready byte stream towards the MIDI UART TX.             |
// | Ports    : data_clk, reset_reg_N (async, active low)                     |
// |            start, midi_ch, base_addr, len     : dump request            |
// |            mem_addr, mem_rd, mem_q            : patch RAM read port     |
// |                                                 (1-cycle latency)        |
// |            tx_byte, tx_valid, tx_ready        : byte stream to UART     |
// |            midibyte_nr, busy, done            : frame status            |
// | Config   : SYX_CHECKSUM_EN - when defined, a 7-bit two's-complement      |
// |            checksum byte is sent between the last data byte and F7.      |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module syx_dump_tx #(
  parameter logic [7:0] SYX_ID = 8'h7D,
  parameter int         ADDR_W = 7
) (
  input  logic              data_clk,
  input  logic              reset_reg_N,
  input  logic              start,
  input  logic [3:0]        midi_ch,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [6:0]        len,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  input  logic [7:0]        mem_q,
  output logic [7:0]        tx_byte,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic [7:0]        midibyte_nr,
  output logic              busy,
  output logic              done
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_F0,
    S_ID,
    S_CH,
    S_LEN,
    S_RD_REQ,
    S_RD_WAIT,
    S_DATA,
`ifdef SYX_CHECKSUM_EN
    S_CKSUM,
`endif
    S_EOX,
    S_FIN
  } state_t;

  localparam logic [7:0] C_SOX = 8'hF0;
  localparam logic [7:0] C_EOX = 8'hF7;

  state_t            state_q, state_d;
  logic [3:0]        ch_q, ch_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [6:0]        len_q, len_d;
  logic [6:0]        idx_q, idx_d;
  logic [7:0]        tx_byte_q, tx_byte_d;
  logic              tx_valid_q, tx_valid_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic              mem_rd_q, mem_rd_d;
  logic [7:0]        nr_q, nr_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
`ifdef SYX_CHECKSUM_EN
  logic [6:0]        cksum_q, cksum_d;
  logic [6:0]        adv_cksum;
`endif

  // advance: a LEN or DATA byte was just accepted; choose between fetching
  // the next data byte and closing the frame, using the updated index.
  logic              advance;
  logic [6:0]        adv_idx;
  logic              xfer;

  assign xfer = tx_valid_q & tx_ready;

  always_ff @(posedge data_clk or negedge reset_reg_N) begin
    if (!reset_reg_N) begin
      state_q    <= S_IDLE;
      ch_q       <= '0;
      base_q     <= '0;
      len_q      <= '0;
      idx_q      <= '0;
      tx_byte_q  <= '0;
      tx_valid_q <= 1'b0;
      mem_addr_q <= '0;
      mem_rd_q   <= 1'b0;
      nr_q       <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
`ifdef SYX_CHECKSUM_EN
      cksum_q    <= '0;
`endif
    end else begin
      state_q    <= state_d;
      ch_q       <= ch_d;
      base_q     <= base_d;
      len_q      <= len_d;
      idx_q      <= idx_d;
      tx_byte_q  <= tx_byte_d;
      tx_valid_q <= tx_valid_d;
      mem_addr_q <= mem_addr_d;
      mem_rd_q   <= mem_rd_d;
      nr_q       <= nr_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
`ifdef SYX_CHECKSUM_EN
      cksum_q    <= cksum_d;
`endif
    end
  end

  always_comb begin
    state_d    = state_q;
    ch_d       = ch_q;
    base_d     = base_q;
    len_d      = len_q;
    idx_d      = idx_q;
    tx_byte_d  = tx_byte_q;
    tx_valid_d = tx_valid_q;
    mem_addr_d = mem_addr_q;
    mem_rd_d   = 1'b0;
    nr_d       = nr_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    advance    = 1'b0;
    adv_idx    = idx_q;
`ifdef SYX_CHECKSUM_EN
    cksum_d    = cksum_q;
    adv_cksum  = cksum_q;
`endif

    if (xfer) begin
      nr_d = nr_q + 8'd1;
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          ch_d       = midi_ch;
          base_d     = base_addr;
          len_d      = len;
          idx_d      = '0;
          nr_d       = '0;
          busy_d     = 1'b1;
          tx_byte_d  = C_SOX;
          tx_valid_d = 1'b1;
          state_d    = S_F0;
`ifdef SYX_CHECKSUM_EN
          cksum_d    = '0;
`endif
        end
      end
      S_F0: begin
        if (xfer) begin
          tx_byte_d = SYX_ID;
          state_d   = S_ID;
        end
      end
      S_ID: begin
        if (xfer) begin
          tx_byte_d = {4'h0, ch_q};
          state_d   = S_CH;
        end
      end
      S_CH: begin
        if (xfer) begin
          tx_byte_d = {1'b0, len_q};
          state_d   = S_LEN;
        end
      end
      S_LEN: begin
        if (xfer) begin
          advance = 1'b1;
          adv_idx = idx_q;
        end
      end
      S_RD_REQ: begin
        // mem_rd_q is high during this state; data returns next cycle.
        state_d = S_RD_WAIT;
      end
      S_RD_WAIT: begin
        // Masking the whole word keeps SysEx data bytes below 8'h80.
        tx_byte_d  = mem_q & 8'h7F;
        tx_valid_d = 1'b1;
        state_d    = S_DATA;
      end
      S_DATA: begin
        if (xfer) begin
          advance   = 1'b1;
          adv_idx   = idx_q + 7'd1;
`ifdef SYX_CHECKSUM_EN
          adv_cksum = cksum_q + tx_byte_q[6:0];
`endif
        end
      end
`ifdef SYX_CHECKSUM_EN
      S_CKSUM: begin
        if (xfer) begin
          tx_byte_d = C_EOX;
          state_d   = S_EOX;
        end
      end
`endif
      S_EOX: begin
        if (xfer) begin
          tx_byte_d  = '0;
          tx_valid_d = 1'b0;
          busy_d     = 1'b0;
          done_d     = 1'b1;
          state_d    = S_FIN;
        end
      end
      S_FIN: begin
        // start is not looked at here, so a request during done is dropped.
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (advance) begin
      idx_d = adv_idx;
`ifdef SYX_CHECKSUM_EN
      cksum_d = adv_cksum;
`endif
      if (adv_idx < len_q) begin
        tx_valid_d = 1'b0;
        mem_rd_d   = 1'b1;
        mem_addr_d = base_q + ADDR_W'(adv_idx);
        state_d    = S_RD_REQ;
      end else begin
`ifdef SYX_CHECKSUM_EN
        tx_byte_d = {1'b0, 7'd0 - adv_cksum};
        state_d   = S_CKSUM;
`else
        tx_byte_d = C_EOX;
        state_d   = S_EOX;
`endif
      end
    end
  end

  assign mem_addr    = mem_addr_q;
  assign mem_rd      = mem_rd_q;
  assign tx_byte     = tx_byte_q;
  assign tx_valid    = tx_valid_q;
  assign midibyte_nr = nr_q;
  assign busy        = busy_q;
  assign done        = done_q;

endmodule
`default_nettype wire

// File: tb/tb_syx_dump_tx.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_syx_dump_tx                                                |
// | Purpose  : Directed self-checking bench for syx_dump_tx. Expected frames |
// |            are written out by hand; the checksum byte is expected only   |
// |            when SYX_CHECKSUM_EN is defined.                              |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_syx_dump_tx;

  logic       clk;
  logic       reset_reg_N;
  logic       start;
  logic [3:0] midi_ch;
  logic [6:0] base_addr;
  logic [6:0] len;
  logic [6:0] mem_addr;
  logic       mem_rd;
  logic [7:0] mem_q;
  logic [7:0] tx_byte;
  logic       tx_valid;
  logic       tx_ready;
  logic [7:0] midibyte_nr;
  logic       busy;
  logic       done;

  syx_dump_tx dut (
    .data_clk    (clk),
    .reset_reg_N (reset_reg_N),
    .start       (start),
    .midi_ch     (midi_ch),
    .base_addr   (base_addr),
    .len         (len),
    .mem_addr    (mem_addr),
    .mem_rd      (mem_rd),
    .mem_q       (mem_q),
    .tx_byte     (tx_byte),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .midibyte_nr (midibyte_nr),
    .busy        (busy),
    .done        (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Patch RAM model with one cycle of read latency.
  logic [7:0] mem [0:127];
  always @(posedge clk) begin
    if (mem_rd) mem_q <= mem[mem_addr];
  end

  int n_cmp = 0;
  int n_err = 0;

  logic [7:0] got[$];
  logic [7:0] nrs[$];
  logic [6:0] addrs[$];
  logic [7:0] exp_b[$];
  logic [6:0] exp_a[$];
  logic       got_done;
  logic       stall_ok;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_tx_byte"},  {24'h0, tx_byte}, 32'h0);
    check({tag, "_tx_valid"}, {31'h0, tx_valid}, 32'h0);
    check({tag, "_mem_addr"}, {25'h0, mem_addr}, 32'h0);
    check({tag, "_mem_rd"},   {31'h0, mem_rd}, 32'h0);
    check({tag, "_nr"},       {24'h0, midibyte_nr}, 32'h0);
    check({tag, "_busy"},     {31'h0, busy}, 32'h0);
    check({tag, "_done"},     {31'h0, done}, 32'h0);
  endtask

  // Issue a start and collect every transferred byte until done. While the
  // byte with index stall_nr is offered, tx_ready is held low for stall_cyc
  // cycles and the offered byte must stay put.
  task automatic run_frame(input logic [3:0] ch, input logic [6:0] base, input logic [6:0] ln,
                           input int stall_nr, input int stall_cyc);
    int         stall_cnt;
    logic [7:0] held;
    got.delete(); nrs.delete(); addrs.delete();
    got_done  = 1'b0;
    stall_ok  = 1'b1;
    stall_cnt = 0;
    held      = 8'h00;
    @(negedge clk);
    start = 1'b1; midi_ch = ch; base_addr = base; len = ln;
    @(negedge clk);
    start = 1'b0;
    for (int cyc = 0; cyc < 500; cyc++) begin
      if (mem_rd) addrs.push_back(mem_addr);
      if (done) begin
        got_done = 1'b1;
        break;
      end
      if (tx_valid && int'(midibyte_nr) == stall_nr && stall_cnt < stall_cyc) begin
        if (stall_cnt == 0) held = tx_byte;
        if (tx_valid !== 1'b1 || tx_byte !== held) stall_ok = 1'b0;
        tx_ready = 1'b0;
        stall_cnt++;
      end else begin
        tx_ready = 1'b1;
      end
      if (tx_valid && tx_ready) begin
        got.push_back(tx_byte);
        nrs.push_back(midibyte_nr);
      end
      @(negedge clk);
    end
  endtask

  task automatic verify_frame(input string tag);
    check({tag, "_done_seen"}, {31'h0, got_done}, 32'h1);
    check({tag, "_nbytes"}, got.size(), exp_b.size());
    for (int i = 0; i < exp_b.size(); i++) begin
      check($sformatf("%s_byte%0d", tag, i),
            (i < got.size()) ? {24'h0, got[i]} : 32'hFFFF_FFFF, {24'h0, exp_b[i]});
      check($sformatf("%s_nr%0d", tag, i),
            (i < nrs.size()) ? {24'h0, nrs[i]} : 32'hFFFF_FFFF, i);
    end
    check({tag, "_nreads"}, addrs.size(), exp_a.size());
    for (int i = 0; i < exp_a.size(); i++) begin
      check($sformatf("%s_addr%0d", tag, i),
            (i < addrs.size()) ? {25'h0, addrs[i]} : 32'hFFFF_FFFF, {25'h0, exp_a[i]});
    end
  endtask

  initial begin
    logic found;
    reset_reg_N = 1'b0;
    start = 1'b0; midi_ch = '0; base_addr = '0; len = '0;
    tx_ready = 1'b0; mem_q = 8'h00;
    for (int i = 0; i < 128; i++) mem[i] = 8'hEE;
    mem[0] = 8'h12; mem[1] = 8'h34;

    // Reset state, during and after reset.
    #12;
    check_quiet("rst_held");
    @(negedge clk); reset_reg_N = 1'b1;
    @(negedge clk);
    check_quiet("rst_released");

    // 1: basic frame, ch=3 base=0 len=2. Checksum = -(12+34) = 3A.
    exp_b = '{8'hF0, 8'h7D, 8'h03, 8'h02, 8'h12, 8'h34};
`ifdef SYX_CHECKSUM_EN
    exp_b.push_back(8'h3A);
`endif
    exp_b.push_back(8'hF7);
    exp_a = '{7'h00, 7'h01};
    run_frame(4'h3, 7'h00, 7'd2, -1, 0);
    verify_frame("basic");
    check("basic_busy_at_done", {31'h0, busy}, 32'h0);
    // start coincident with the done cycle must be dropped.
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("done_one_cycle", {31'h0, done}, 32'h0);
    check("fin_start_ignored_busy", {31'h0, busy}, 32'h0);
    @(negedge clk);
    check("fin_start_ignored_valid", {31'h0, tx_valid}, 32'h0);
    check("fin_start_ignored_busy2", {31'h0, busy}, 32'h0);

    // 3: len=0, no memory reads.
    exp_b = '{8'hF0, 8'h7D, 8'h09, 8'h00};
`ifdef SYX_CHECKSUM_EN
    exp_b.push_back(8'h00);
`endif
    exp_b.push_back(8'hF7);
    exp_a.delete();
    run_frame(4'h9, 7'h33, 7'd0, -1, 0);
    verify_frame("len0");

    // 4: address wrap and bit7 stripping; data 7F 01 05 sum 05, cksum 7B.
    mem[7'h7E] = 8'hFF; mem[7'h7F] = 8'h81; mem[7'h00] = 8'h05;
    exp_b = '{8'hF0, 8'h7D, 8'h01, 8'h03, 8'h7F, 8'h01, 8'h05};
`ifdef SYX_CHECKSUM_EN
    exp_b.push_back(8'h7B);
`endif
    exp_b.push_back(8'hF7);
    exp_a = '{7'h7E, 7'h7F, 7'h00};
    run_frame(4'h1, 7'h7E, 7'd3, -1, 0);
    verify_frame("wrap");

    // 5: back-pressure on the ID byte for 10 cycles. Cksum = -2A = 56.
    mem[7'h10] = 8'h2A;
    exp_b = '{8'hF0, 8'h7D, 8'h05, 8'h01, 8'h2A};
`ifdef SYX_CHECKSUM_EN
    exp_b.push_back(8'h56);
`endif
    exp_b.push_back(8'hF7);
    exp_a = '{7'h10};
    run_frame(4'h5, 7'h10, 7'd1, 1, 10);
    verify_frame("stall");
    check("stall_id_stable", {31'h0, stall_ok}, 32'h1);

    // 6: asynchronous reset while the first data byte is being offered.
    mem[7'h20] = 8'h01; mem[7'h21] = 8'h02; mem[7'h22] = 8'h03;
    @(negedge clk);
    start = 1'b1; midi_ch = 4'h3; base_addr = 7'h20; len = 7'd3; tx_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    found = 1'b0;
    for (int cyc = 0; cyc < 50; cyc++) begin
      if (tx_valid && midibyte_nr == 8'd4) begin
        tx_ready = 1'b0;
        found = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check("abort_reached_data", {31'h0, found}, 32'h1);
    check("abort_data_byte", {24'h0, tx_byte}, 32'h01);
    #2 reset_reg_N = 1'b0;
    #1;
    check_quiet("abort_rst");
    @(negedge clk);
    reset_reg_N = 1'b1;
    // Fresh frame: data 01 (from 81) and 05, sum 06, cksum 7A.
    exp_b = '{8'hF0, 8'h7D, 8'h0F, 8'h02, 8'h01, 8'h05};
`ifdef SYX_CHECKSUM_EN
    exp_b.push_back(8'h7A);
`endif
    exp_b.push_back(8'hF7);
    exp_a = '{7'h7F, 7'h00};
    run_frame(4'hF, 7'h7F, 7'd2, -1, 0);
    verify_frame("after_abort");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
